shift_unit_scheduler: RTL and testbench

- Shares one 32-bit logical-right barrel shifter (Barrel_Shifter_32bit) between two requesters, e.g. the ALU shift path and the multiply/divide sequencer.
- Synthesizes four shift ops (SRL, SLL, SRA, ROR) by sequencing one or two passes through that single right-only shifter.
- Round-robin arbitration; valid/ready handshake on each request port and on the response port.
- Sits between the execute-stage requesters and the shifter datapath.

---
 rtl/shift_sched_pkg.sv | 35 +++
 rtl/shift_unit_scheduler_if.sv | 44 ++++
 rtl/Barrel_Shifter_32bit.sv | 24 ++
 rtl/shift_rr_arbiter2.sv | 40 ++++
 rtl/shift_unit_scheduler.sv | 162 ++++++++++++++++
 tb/tb_shift_unit_scheduler.sv | 190 +++++++++++++++++++
 6 files changed

// File: rtl/shift_sched_pkg.sv
// Shared types and helpers for the shift unit scheduler.
//   - op_e    : requested shift operation
//   - state_e : scheduler FSM state
//   - ALL_ONES: all-ones datapath word, used to build the SRA sign mask
//   - rev32() : 32-bit bit reversal (bit i -> bit 31-i)
package shift_sched_pkg;

  localparam int unsigned DataW  = 32;
  localparam int unsigned ShamtW = 5;

  localparam logic [DataW-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = x[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_unit_scheduler_if.sv
// Bus bundle between the two execute-stage requesters, the response consumer and
// the shift unit scheduler.
//   r0_* / r1_* : request ports (valid, op, a, shamt in; ready back)
//   rsp_*       : response port (valid, id, result out; ready back)
// master: requester/consumer side. slave: scheduler side.
interface shift_unit_scheduler_if;
  import shift_sched_pkg::*;

  logic              r0_valid;
  logic [1:0]        r0_op;
  logic [DataW-1:0]  r0_a;
  logic [ShamtW-1:0] r0_shamt;
  logic              r0_ready;

  logic              r1_valid;
  logic [1:0]        r1_op;
  logic [DataW-1:0]  r1_a;
  logic [ShamtW-1:0] r1_shamt;
  logic              r1_ready;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DataW-1:0]  rsp_result;
  logic              rsp_ready;

  modport master (
    output r0_valid, r0_op, r0_a, r0_shamt,
    input  r0_ready,
    output r1_valid, r1_op, r1_a, r1_shamt,
    input  r1_ready,
    input  rsp_valid, rsp_id, rsp_result,
    output rsp_ready
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_shamt,
    output r0_ready,
    input  r1_valid, r1_op, r1_a, r1_shamt,
    output r1_ready,
    output rsp_valid, rsp_id, rsp_result,
    input  rsp_ready
  );

endinterface

// File: rtl/Barrel_Shifter_32bit.sv
// 32-bit logical-right barrel shifter, purely combinational.
//   data_i  : value to shift
//   shamt_i : shift amount 0..31
//   data_o  : data_i >> shamt_i, zero-filled from the top
module Barrel_Shifter_32bit (
  input  logic [31:0] data_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] data_o
);

  logic [31:0] s;

  // Five log2 stages: stage i shifts by 2**i when shamt_i[i] is set.
  always_comb begin
    s = data_i;
    for (int i = 0; i < 5; i++) begin
      if (shamt_i[i]) begin
        s = s >> (1 << i);
      end
    end
    data_o = s;
  end

endmodule

// File: rtl/shift_rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : arbitration allowed this cycle (scheduler idle)
//   req_i        : request valids {r1, r0}
//   gnt_o        : one-hot grant, zero when disabled or nobody requests
// Priority passes to the loser whenever a grant is issued; since the grant
// doubles as ready, every grant is an accept.
module shift_rr_arbiter2 #(
  parameter bit ResetPrio = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic prio_q;

  always_comb begin
    gnt_o = '0;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= ResetPrio;
    end else if (|gnt_o) begin
      prio_q <= ~gnt_o[1];
    end
  end

endmodule

// File: rtl/shift_unit_scheduler.sv
// Shares one right-only barrel shifter between two requesters and builds
// SRL/SLL/SRA/ROR out of one or two passes through it.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : request ports r0/r1 and the response port (slave side)
//   busy : high whenever the FSM is not idle
// Flow: IDLE (arbitrate/accept) -> PASS1 -> [PASS2] -> DONE. DONE spends its
// first cycle registering the response, then holds it until rsp_ready.
module shift_unit_scheduler
  import shift_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned SHAMT_W    = 5,
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  shift_unit_scheduler_if.slave  bus,
  output logic                   busy
);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [DATA_W-1:0]   a_q;
  logic [SHAMT_W-1:0]  shamt_q;
  logic                id_q;
  logic [DATA_W-1:0]   p1_q;
  logic [DATA_W-1:0]   res_q;
  logic                rsp_valid_q;

  logic [1:0]          gnt;
  logic                arb_en;
  logic                accept;
  logic                rsp_fire;

  logic [DATA_W-1:0]   sh_in;
  logic [SHAMT_W-1:0]  sh_amt;
  logic [DATA_W-1:0]   sh_out;
  logic [DATA_W-1:0]   pass2_res;

  // ---------------------------------------------------------------------------
  // Arbitration: ready is the grant, only offered while idle and out of reset.
  // ---------------------------------------------------------------------------
  assign arb_en = (state_q == IDLE) && !rst;

  shift_rr_arbiter2 #(
    .ResetPrio (1'(RESET_PRIO))
  ) u_arb (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (arb_en),
    .req_i ({bus.r1_valid, bus.r0_valid}),
    .gnt_o (gnt)
  );

  assign bus.r0_ready = gnt[0];
  assign bus.r1_ready = gnt[1];
  assign accept       = |gnt;

  // ---------------------------------------------------------------------------
  // Shifter drive. SLL runs on the reversed operand; SRA's second pass shifts
  // ones to form the sign-fill mask; ROR's second pass recovers the bits that
  // wrapped around by shifting rev(a) right by (32 - shamt) mod 32.
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_in  = '0;
    sh_amt = '0;
    unique case (state_q)
      PASS1: begin
        sh_in  = (op_q == OP_SLL) ? rev32(a_q) : a_q;
        sh_amt = shamt_q;
      end
      PASS2: begin
        if (op_q == OP_SRA) begin
          sh_in  = ALL_ONES;
          sh_amt = shamt_q;
        end else begin
          sh_in  = rev32(a_q);
          sh_amt = SHAMT_W'(0) - shamt_q;
        end
      end
      default: begin
        sh_in  = '0;
        sh_amt = '0;
      end
    endcase
  end

  Barrel_Shifter_32bit u_shifter (
    .data_i  (sh_in),
    .shamt_i (sh_amt),
    .data_o  (sh_out)
  );

  always_comb begin
    if (op_q == OP_SRA) begin
      pass2_res = p1_q | (a_q[DATA_W-1] ? ~sh_out : '0);
    end else begin
      pass2_res = p1_q | rev32(sh_out);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign rsp_fire = (state_q == DONE) && rsp_valid_q && bus.rsp_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = PASS1;
      PASS1:   state_d = (op_q == OP_SRL || op_q == OP_SLL) ? DONE : PASS2;
      PASS2:   state_d = DONE;
      DONE:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_SRL;
      a_q         <= '0;
      shamt_q     <= '0;
      id_q        <= 1'b0;
      p1_q        <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_q    <= op_e'(gnt[1] ? bus.r1_op : bus.r0_op);
        a_q     <= gnt[1] ? bus.r1_a : bus.r0_a;
        shamt_q <= gnt[1] ? bus.r1_shamt : bus.r0_shamt;
        id_q    <= gnt[1];
      end

      if (state_q == PASS1) begin
        p1_q <= sh_out;
      end else if (state_q == PASS2) begin
        p1_q <= pass2_res;
      end

      // First DONE cycle loads the response; it then holds until taken.
      if (state_q == DONE) begin
        if (!rsp_valid_q) begin
          rsp_valid_q <= 1'b1;
          res_q       <= (op_q == OP_SLL) ? rev32(p1_q) : p1_q;
        end else if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_shift_unit_scheduler.sv
// Directed bench for shift_unit_scheduler: reset values, each op with
// hand-computed results and latencies, round-robin under contention,
// response backpressure and reset abort.
module tb_shift_unit_scheduler;
  import shift_sched_pkg::*;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;

  shift_unit_scheduler_if bus ();

  shift_unit_scheduler #(
    .DATA_W     (32),
    .SHAMT_W    (5),
    .RESET_PRIO (0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, check grant, latency, result, optional backpressure hold
  // and the handshake back to idle.
  task automatic do_op(input string tag, input logic id, input op_e op,
                       input logic [31:0] a, input logic [4:0] sh,
                       input logic [31:0] exp, input int lat, input int hold);
    int n;
    @(negedge clk);
    if (id) begin
      bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_a = a; bus.r1_shamt = sh;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_a = a; bus.r0_shamt = sh;
    end
    #1;
    check({tag, " ready"}, 32'({bus.r1_ready, bus.r0_ready}), id ? 32'd2 : 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    #1;
    check({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, bus.rsp_result, exp);
    check({tag, " id"}, 32'(bus.rsp_id), 32'(id));
    if (hold > 0) begin
      bus.r0_valid = 1'b1;
      bus.r1_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        #1;
        check({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, " hold result"}, bus.rsp_result, exp);
        check({tag, " hold ready"}, 32'({bus.r1_ready, bus.r0_ready}), 32'd0);
        check({tag, " hold busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
      end
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    check({tag, " rsp drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          ng;
    logic [3:0]  gids;
    logic        seen;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_shamt = '0;
    bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_shamt = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_id", 32'(bus.rsp_id), 32'd0);
    check("reset rsp_result", bus.rsp_result, 32'd0);
    check("reset ready", 32'({bus.r1_ready, bus.r0_ready}), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Contention straight out of reset: grants must alternate 0,1,0,1.
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = OP_SRL; bus.r0_a = 32'h0000_00F0; bus.r0_shamt = 5'd4;
    bus.r1_valid = 1'b1; bus.r1_op = OP_SRL; bus.r1_a = 32'h0000_0F00; bus.r1_shamt = 5'd4;
    bus.rsp_ready = 1'b1;
    ng = 0;
    gids = '0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (bus.r0_ready || bus.r1_ready) begin
        gids[ng] = bus.r1_ready;
        ng++;
      end
      if (bus.rsp_valid) begin
        check("contention result", bus.rsp_result, bus.rsp_id ? 32'h0000_00F0 : 32'h0000_000F);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.r0_valid = 1'b0;
    bus.r1_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.rsp_valid) begin
        check("contention drain result", bus.rsp_result,
              bus.rsp_id ? 32'h0000_00F0 : 32'h0000_000F);
      end
      if (!busy) break;
      @(posedge clk);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check("contention grants", 32'(ng), 32'd4);
    check("contention order", 32'(gids), 32'h0000_000A);
    check("contention idle", 32'(busy), 32'd0);

    do_op("SRL r0", 1'b0, OP_SRL, 32'h8000_0001, 5'd4, 32'h0800_0000, 2, 0);
    do_op("SLL r1 31", 1'b1, OP_SLL, 32'h0000_0003, 5'd31, 32'h8000_0000, 2, 0);
    do_op("SLL r1 0", 1'b1, OP_SLL, 32'h1234_5678, 5'd0, 32'h1234_5678, 2, 0);
    do_op("SRA neg", 1'b0, OP_SRA, 32'hF000_0000, 5'd4, 32'hFF00_0000, 3, 5);
    do_op("SRA pos", 1'b1, OP_SRA, 32'h7000_0000, 5'd4, 32'h0700_0000, 3, 0);
    do_op("SRA 31", 1'b0, OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 3, 0);
    do_op("ROR 1", 1'b1, OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 3, 0);
    do_op("ROR 0", 1'b0, OP_ROR, 32'h1234_5678, 5'd0, 32'h1234_5678, 3, 0);
    do_op("ROR 8", 1'b1, OP_ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 3, 0);

    // Reset during PASS2 of an SRA: op is dropped, no response ever appears.
    @(negedge clk);
    bus.r0_valid = 1'b1; bus.r0_op = OP_SRA; bus.r0_a = 32'hF000_0000; bus.r0_shamt = 5'd4;
    @(posedge clk);
    @(negedge clk);
    bus.r0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("abort no response", 32'(seen), 32'd0);
    do_op("post-abort r1", 1'b1, OP_SRL, 32'hF000_0000, 5'd4, 32'h0F00_0000, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
